// File: rtl/systolic_os_array_ft_if.sv
// Job/stream port bundle for the output-stationary systolic GEMM engine.
// The host side drives jobs and operands; the engine side returns the drained result columns.
interface systolic_os_array_ft_if #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned D_W   = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned K_MAX = 16
) ();
    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    logic                             start;
    logic [KW-1:0]                    k_len;
    logic                             fault_en;
    logic [RW-1:0]                    fault_row;
    logic [CW-1:0]                    fault_col;
    logic [1:0]                       fault_target;
    logic [ACC_W-1:0]                 fault_mask;
    logic [ROWS-1:0][D_W-1:0]         a_in;
    logic [COLS-1:0][D_W-1:0]         b_in;
    logic                             in_valid;
    logic                             in_ready;
    logic [ROWS-1:0][ACC_W-1:0]       out_data;
    logic [CW-1:0]                    out_col;
    logic                             out_valid;
    logic                             out_ready;
    logic                             busy;
    logic                             done;

    modport master (
        output start, k_len, fault_en, fault_row, fault_col, fault_target, fault_mask,
        output a_in, b_in, in_valid, out_ready,
        input  in_ready, out_data, out_col, out_valid, busy, done
    );

    modport slave (
        input  start, k_len, fault_en, fault_row, fault_col, fault_target, fault_mask,
        input  a_in, b_in, in_valid, out_ready,
        output in_ready, out_data, out_col, out_valid, busy, done
    );
endinterface

// File: rtl/systolic_os_array_ft.sv
// Output-stationary systolic GEMM engine, C = A * B, with one programmable faulty PE.
// Operands arrive unskewed; A lanes and B lanes are skewed internally, every operand carries a
// valid bit through the array, and results drain column by column (rightmost first).
module systolic_os_array_ft #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned D_W   = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned K_MAX = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    systolic_os_array_ft_if.slave bus
);
    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned FW = $clog2(ROWS + COLS);
    localparam int unsigned PW = 2 * D_W;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]    drain_col_q, drain_col_d;
    logic [KW-1:0]    k_len_q;
    logic             fault_en_q;
    logic [RW-1:0]    fault_row_q;
    logic [CW-1:0]    fault_col_q;
    logic [1:0]       fault_target_q;
    logic [ACC_W-1:0] fault_mask_q;

    logic             job_start;
    logic             in_ready;
    logic             accept;
    logic             drain_fire;

    logic [D_W-1:0]   a_lane   [ROWS];
    logic             a_lane_v [ROWS];
    logic [D_W-1:0]   b_lane   [COLS];
    logic             b_lane_v [COLS];
    logic [D_W-1:0]   a_q      [ROWS][COLS];
    logic             av_q     [ROWS][COLS];
    logic [D_W-1:0]   b_q      [ROWS][COLS];
    logic             bv_q     [ROWS][COLS];
    logic [ACC_W-1:0] acc_q    [ROWS][COLS];

    assign in_ready   = (state_q == StLoad) && (beat_cnt_q != k_len_q);
    assign accept     = in_ready && bus.in_valid;
    assign drain_fire = (state_q == StDrain) && bus.out_ready;

    // Next-state and counter updates for the job sequencer.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        drain_col_d = drain_col_q;
        job_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StLoad;
                    beat_cnt_d = '0;
                    job_start  = 1'b1;
                end
            end
            StLoad: begin
                // k_len == 0 falls straight through with in_ready never raised.
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_q + KW'(1) == k_len_q) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                    end
                end else if (beat_cnt_q == k_len_q) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = StDrain;
                    drain_col_d = COL_LAST;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            StDrain: begin
                if (drain_fire) begin
                    if (drain_col_q == '0) begin
                        state_d = StDone;
                    end else begin
                        drain_col_d = drain_col_q - CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state, counters and the per-job configuration snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            beat_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            drain_col_q    <= '0;
            k_len_q        <= '0;
            fault_en_q     <= 1'b0;
            fault_row_q    <= '0;
            fault_col_q    <= '0;
            fault_target_q <= 2'd3;
            fault_mask_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            drain_col_q <= drain_col_d;
            if (job_start) begin
                k_len_q        <= bus.k_len;
                fault_en_q     <= bus.fault_en;
                fault_row_q    <= bus.fault_row;
                fault_col_q    <= bus.fault_col;
                fault_target_q <= bus.fault_target;
                fault_mask_q   <= bus.fault_mask;
            end
        end
    end

    // A skew: lane r passes through r extra registers before entering column 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_lane[r]   = bus.a_in[r];
            assign a_lane_v[r] = accept;
        end else begin : g_chain
            logic [D_W-1:0] d_q [r];
            logic           v_q [r];
            // Shift lane r down its delay chain; valid follows the data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= bus.a_in[r];
                    v_q[0] <= accept;
                    for (int i = 1; i < r; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end
            assign a_lane[r]   = d_q[r-1];
            assign a_lane_v[r] = v_q[r-1];
        end
    end

    // B skew: lane c passes through c extra registers before entering row 0.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_lane[c]   = bus.b_in[c];
            assign b_lane_v[c] = accept;
        end else begin : g_chain
            logic [D_W-1:0] d_q [c];
            logic           v_q [c];
            // Shift lane c down its delay chain; valid follows the data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= bus.b_in[c];
                    v_q[0] <= accept;
                    for (int i = 1; i < c; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end
            assign b_lane[c]   = d_q[c-1];
            assign b_lane_v[c] = v_q[c-1];
        end
    end

    // PE grid: each PE registers its operands (which double as the forwarding registers).
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [D_W-1:0]   a_src, b_src, a_op, b_op, a_r, b_r;
            logic             a_src_v, b_src_v, av_r, bv_r, hit;
            logic [PW-1:0]    prod;
            logic [ACC_W-1:0] sum, acc_r;

            if (c == 0) begin : g_a_edge
                assign a_src   = a_lane[r];
                assign a_src_v = a_lane_v[r];
            end else begin : g_a_fwd
                assign a_src   = a_q[r][c-1];
                assign a_src_v = av_q[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_src   = b_lane[c];
                assign b_src_v = b_lane_v[c];
            end else begin : g_b_fwd
                assign b_src   = b_q[r-1][c];
                assign b_src_v = bv_q[r-1][c];
            end

            assign hit = fault_en_q && (fault_row_q == RW'(r)) && (fault_col_q == CW'(c));

            // Multiply-accumulate; a fault corrupts only this PE's local use, never the forward path.
            always_comb begin
                a_op = a_r;
                b_op = b_r;
                if (hit && (fault_target_q == 2'd1)) a_op = a_r ^ fault_mask_q[D_W-1:0];
                if (hit && (fault_target_q == 2'd0)) b_op = b_r ^ fault_mask_q[D_W-1:0];
                prod = PW'(a_op) * PW'(b_op);
                sum  = acc_r + ACC_W'(prod);
                if (hit && (fault_target_q == 2'd2)) sum = sum ^ fault_mask_q;
            end

            // Operand pipeline and accumulator; accumulate only on valid operand pairs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r   <= '0;
                    av_r  <= 1'b0;
                    b_r   <= '0;
                    bv_r  <= 1'b0;
                    acc_r <= '0;
                end else begin
                    a_r  <= a_src;
                    av_r <= a_src_v;
                    b_r  <= b_src;
                    bv_r <= b_src_v;
                    if (job_start) begin
                        acc_r <= '0;
                    end else if (av_r && bv_r) begin
                        acc_r <= sum;
                    end
                end
            end

            assign a_q[r][c]   = a_r;
            assign av_q[r][c]  = av_r;
            assign b_q[r][c]   = b_r;
            assign bv_q[r][c]  = bv_r;
            assign acc_q[r][c] = acc_r;
        end
    end

    // Drain mux: present the selected accumulator column, zero outside DRAIN.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            bus.out_data[r] = (state_q == StDrain) ? acc_q[r][drain_col_q] : '0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDrain);
    assign bus.out_col   = (state_q == StDrain) ? drain_col_q : '0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
endmodule

// File: tb/tb_systolic_os_array_ft.sv
// Bench for systolic_os_array_ft: directed jobs plus random jobs checked against a plain
// matrix-multiply reference model with the single-PE fault rule applied.
module tb_systolic_os_array_ft;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned D_W   = 8;
    localparam int unsigned ACC_W = 24;
    localparam int unsigned K_MAX = 16;
    localparam int unsigned KW    = $clog2(K_MAX + 1);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_os_array_ft_if #(
        .ROWS(ROWS), .COLS(COLS), .D_W(D_W), .ACC_W(ACC_W), .K_MAX(K_MAX)
    ) bus ();

    systolic_os_array_ft #(
        .ROWS(ROWS), .COLS(COLS), .D_W(D_W), .ACC_W(ACC_W), .K_MAX(K_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [D_W-1:0]   a_m   [ROWS][K_MAX];
    logic [D_W-1:0]   b_m   [K_MAX][COLS];
    logic [ACC_W-1:0] c_exp [ROWS][COLS];
    int unsigned      job_k;
    logic             f_en;
    int unsigned      f_row, f_col;
    logic [1:0]       f_tgt;
    logic [ACC_W-1:0] f_mask;
    int               gap_mode;    // 0 always valid, 1 toggle, 2 random
    int               stall_mode;  // 0 none, 1 three-cycle stall on beat 1, 2 random

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: C = A*B over job_k beats, faulty PE rule applied per update.
    function automatic void compute_model();
        logic [D_W-1:0]   a, b;
        logic [ACC_W-1:0] acc;
        logic             hit;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                acc = '0;
                hit = f_en && (f_tgt != 2'd3) && (r == int'(f_row)) && (c == int'(f_col));
                for (int k = 0; k < int'(job_k); k++) begin
                    a = a_m[r][k];
                    b = b_m[k][c];
                    if (hit && f_tgt == 2'd1) a = a ^ f_mask[D_W-1:0];
                    if (hit && f_tgt == 2'd0) b = b ^ f_mask[D_W-1:0];
                    acc = acc + ACC_W'(a) * ACC_W'(b);
                    if (hit && f_tgt == 2'd2) acc = acc ^ f_mask;
                end
                c_exp[r][c] = acc;
            end
        end
    endfunction

    task automatic run_job(input string name);
        int   n_acc, n_cyc, lat, stall, w;
        logic v;
        compute_model();
        bus.k_len        = KW'(job_k);
        bus.fault_en     = f_en;
        bus.fault_row    = RW'(f_row);
        bus.fault_col    = CW'(f_col);
        bus.fault_target = f_tgt;
        bus.fault_mask   = f_mask;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        // Config changes mid-job must be ignored.
        bus.k_len        = KW'($urandom);
        bus.fault_en     = 1'($urandom);
        bus.fault_row    = RW'($urandom);
        bus.fault_col    = CW'($urandom);
        bus.fault_target = 2'($urandom);
        bus.fault_mask   = ACC_W'($urandom);
        n_acc = 0;
        n_cyc = 0;
        while (n_acc < int'(job_k) && n_cyc < 500) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (n_cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            for (int r = 0; r < ROWS; r++) bus.a_in[r] = a_m[r][n_acc];
            for (int c = 0; c < COLS; c++) bus.b_in[c] = b_m[n_acc][c];
            bus.start = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
            v = v && bus.in_ready;
            tick();
            n_cyc++;
            if (v) n_acc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({name, "_beats"}, 64'(n_acc), 64'(job_k));
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            bus.a_in     = '1;
            bus.b_in     = '1;
            bus.in_valid = 1'($urandom_range(0, 1));
            check({name, "_no_in_ready"}, 64'(bus.in_ready), 64'd0);
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        if (job_k > 0) check({name, "_latency"}, 64'(lat), 64'(ROWS + COLS + 1));
        for (int beat = 0; beat < COLS; beat++) begin
            int col = COLS - 1 - beat;
            stall = (stall_mode == 1) ? ((beat == 1) ? 3 : 0) :
                    (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s <= stall; s++) begin
                bus.out_ready = (s == stall);
                check($sformatf("%s_valid_b%0d", name, beat), 64'(bus.out_valid), 64'd1);
                check($sformatf("%s_col_b%0d", name, beat), 64'(bus.out_col), 64'(col));
                for (int r = 0; r < ROWS; r++)
                    check($sformatf("%s_data_b%0d_r%0d", name, beat, r),
                          64'(bus.out_data[r]), 64'(c_exp[r][col]));
                tick();
            end
        end
        bus.out_ready = 1'b0;
        check({name, "_done"}, 64'(bus.done), 64'd1);
        check({name, "_no_extra_beat"}, 64'(bus.out_valid), 64'd0);
        w = 0;
        tick();
        check({name, "_done_once"}, 64'(bus.done), 64'd0);
        check({name, "_idle"}, 64'(bus.busy), 64'd0);
        w++;
    endtask

    task automatic setup_ones(input int unsigned k);
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < K_MAX; i++) a_m[r][i] = 8'd1;
        for (int i = 0; i < K_MAX; i++)
            for (int c = 0; c < COLS; c++) b_m[i][c] = 8'd1;
        job_k = k;
        f_en = 1'b0; f_row = 0; f_col = 0; f_tgt = 2'd3; f_mask = '0;
        gap_mode = 0; stall_mode = 0;
    endtask

    task automatic setup_identity();
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < K_MAX; i++) a_m[r][i] = (r == i) ? 8'd1 : 8'd0;
        for (int i = 0; i < K_MAX; i++)
            for (int c = 0; c < COLS; c++) b_m[i][c] = D_W'(4 * i + c + 1);
        job_k = 4;
        f_en = 1'b0; f_row = 0; f_col = 0; f_tgt = 2'd3; f_mask = '0;
        gap_mode = 0; stall_mode = 0;
    endtask

    initial begin
        int w;
        bus.start = 1'b0; bus.k_len = '0; bus.fault_en = 1'b0; bus.fault_row = '0;
        bus.fault_col = '0; bus.fault_target = 2'd3; bus.fault_mask = '0;
        bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_col", 64'(bus.out_col), 64'd0);
        for (int r = 0; r < ROWS; r++) check("rst_out_data", 64'(bus.out_data[r]), 64'd0);
        rst_n = 1'b1;
        tick();

        setup_identity();
        run_job("t1_ident");
        setup_identity();
        stall_mode = 1;
        run_job("t2_stall");
        setup_ones(3);
        gap_mode = 1;
        run_job("t3_gaps");
        setup_ones(3);
        f_en = 1'b1; f_row = 0; f_col = 0; f_tgt = 2'd1; f_mask = 24'h000002;
        run_job("t4_fault_a");
        setup_ones(3);
        f_en = 1'b1; f_row = 1; f_col = 2; f_tgt = 2'd2; f_mask = 24'h000001;
        run_job("t5_fault_acc");
        setup_ones(0);
        run_job("t6_k0");

        // Reset in the middle of a drain discards the job immediately.
        setup_ones(0);
        bus.k_len = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 100) begin
            tick();
            w++;
        end
        check("t6_drain_reached", 64'(bus.out_valid), 64'd1);
        check("t6_drain_col", 64'(bus.out_col), 64'(COLS - 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_out_col", 64'(bus.out_col), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        for (int r = 0; r < ROWS; r++) check("t6_rst_out_data", 64'(bus.out_data[r]), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        setup_identity();
        run_job("t6_after_rst");

        for (int j = 0; j < 6; j++) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < K_MAX; i++) a_m[r][i] = D_W'($urandom);
            for (int i = 0; i < K_MAX; i++)
                for (int c = 0; c < COLS; c++) b_m[i][c] = D_W'($urandom);
            job_k      = $urandom_range(0, K_MAX);
            f_en       = 1'($urandom_range(0, 1));
            f_row      = $urandom_range(0, ROWS - 1);
            f_col      = $urandom_range(0, COLS - 1);
            f_tgt      = 2'($urandom_range(0, 3));
            f_mask     = ACC_W'($urandom);
            gap_mode   = 2;
            stall_mode = 2;
            run_job($sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
